lsu_rresp_sram_wr: RTL and testbench
====================================

Name: lsu_rresp_sram_wr

Overview:
- Downstream consumer of the AXI read-interface response stream (axi_lsu_rid/rdata/rresp/rlast/rvld, lsu_axi_rrdy).
- Holds a 16-entry tag table indexed by ID[3:0]. Each entry records the destination local-SRAM address and the expected beat count of an outstanding read.
- Each accepted response beat becomes one registered SRAM write at the entry's running address.
- Reports per-transaction completion, error status and an all-idle indication to the LSU.

Parameters:
- ID_WIDTH, 8, width of the response ID; only [3:0] indexes the table.
- DATA_WIDTH, 64, response/SRAM data width.
- SADDR_WIDTH, 12, local SRAM word address width.
- NUM_TAG, 16, tag table depth; fixed at 16 (4-bit index).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-high (1 = reset), port name kept per codebase convention.
- cmd_vld  in  1  register a new outstanding read.
- cmd_rid  in  4  tag index to allocate.
- cmd_sram_addr  in  SADDR_WIDTH  first SRAM word address.
- cmd_beats  in  8  expected beats minus 1 (AXI LEN encoding).
- cmd_rdy  out  1  selected tag is free.
- axi_lsu_rvld  in  1  response beat valid.
- axi_lsu_rid  in  ID_WIDTH  response ID.
- axi_lsu_rdata  in  DATA_WIDTH  beat data.
- axi_lsu_rresp  in  2  beat response code.
- axi_lsu_rlast  in  1  last beat.
- lsu_axi_rrdy  out  1  beat accept.
- sram_we  out  1  SRAM write strobe.
- sram_waddr  out  SADDR_WIDTH  SRAM write address.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_wrdy  in  1  SRAM accepts write this cycle.
- done_vld  out  1  one-cycle completion pulse.
- done_rid  out  4  completed tag.
- done_err  out  1  completion had error.
- idle  out  1  no tag active and no write pending.

Behaviour:
- Reset (rst_n=1 at a clk edge): all tags FREE; sram_we=0, sram_waddr=0, sram_wdata=0, done_vld=0, done_rid=0, done_err=0, lsu_axi_rrdy=1, cmd_rdy=1, idle=1. Reset mid-burst drops all state; no further writes or done pulses are issued for pre-reset tags.
- Per-tag state machine:
  - FREE -> ACTIVE on cmd_vld & cmd_rdy. Loads addr=cmd_sram_addr, remaining=cmd_beats, err=0.
  - ACTIVE -> FREE on an accepted beat with rlast=1.
- cmd_rdy = tag[cmd_rid] is FREE. cmd_vld while cmd_rdy=0 is ignored.
- Write stage: one register stage, pend_vld, driving sram_we.
- lsu_axi_rrdy = ~pend_vld | sram_wrdy. The pipeline advances when the SRAM accepts.
- Beat accept (axi_lsu_rvld & lsu_axi_rrdy):
  - Loads pend: waddr=tag.addr, wdata=rdata.
  - tag.addr += 1, wrapping modulo 2^SADDR_WIDTH.
  - tag.remaining -= 1, saturating at 0.
  - tag.err |= (rresp!=0).
  - Latency: beat accepted at cycle N gives sram_we=1 at N+1, held until sram_wrdy.
- Beat for a FREE tag: still accepted (no stall) and not written to SRAM. Raises done_vld with done_err=1 for that rid in the next cycle.
- Completion: rlast beat accepted at N gives done_vld=1 at N+1 with done_rid and done_err (err including that beat's rresp). The pulse is independent of SRAM write acceptance.
- Simultaneous cmd_vld to tag X and final beat freeing tag X in the same cycle: cmd_rdy uses the registered state, so the cmd is refused and succeeds next cycle.
- Simultaneous cmd_vld and beat on different tags: both take effect.
- idle = no ACTIVE tag & ~pend_vld.

Optional Feature:
- Macro LSU_RRESP_BEAT_CHK_EN.
- Defined:
  - rlast arriving while remaining != 0 sets done_err=1.
  - A non-last beat arriving while remaining == 0 sets tag.err and is not written to SRAM.
- Undefined: beat count is not checked. Only rresp and unknown-tag errors set done_err. remaining logic is removed.

Test Plan:
- Cmd rid=3, addr=0x100, beats=3; 4 beats rid=3 data 0xA0..0xA3, rresp=0, last on 4th, sram_wrdy=1 -> writes 0x100..0x103 with 0xA0..0xA3, each one cycle after accept; done_vld rid=3 err=0; idle=1 after.
- Interleave: tags 1 (addr 0x010) and 2 (addr 0x020), 2 beats each, alternating -> writes 0x010,0x020,0x011,0x021; two done pulses, err=0.
- sram_wrdy=0 for 3 cycles during a burst -> lsu_axi_rrdy=0 while pend is held, sram_we stays 1 with stable addr/data, no beat lost.
- Beat with rresp=2 mid-burst on tag 5 -> done_err=1 for rid=5. Beat for FREE rid=7 -> no SRAM write, done_vld rid=7 err=1.
- Addr 0xFFF, beats=1 -> writes 0xFFF then 0x000. Cmd to an active tag -> cmd_rdy=0.
- With LSU_RRESP_BEAT_CHK_EN: beats=3 but rlast on 2nd beat -> done_err=1. Reset asserted mid-burst -> all outputs at reset values, cmd_rdy=1 for all tags.

Source files
------------

// File: rtl/lsu_rresp_sram_wr_if.sv
// lsu_rresp_sram_wr_if: command, AXI read-response, SRAM-write and completion signals of lsu_rresp_sram_wr.
interface lsu_rresp_sram_wr_if #(
    parameter int ID_WIDTH    = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int SADDR_WIDTH = 12
);
    logic                   cmd_vld;
    logic [3:0]             cmd_rid;
    logic [SADDR_WIDTH-1:0] cmd_sram_addr;
    logic [7:0]             cmd_beats;
    logic                   cmd_rdy;
    logic                   axi_lsu_rvld;
    logic [ID_WIDTH-1:0]    axi_lsu_rid;
    logic [DATA_WIDTH-1:0]  axi_lsu_rdata;
    logic [1:0]             axi_lsu_rresp;
    logic                   axi_lsu_rlast;
    logic                   lsu_axi_rrdy;
    logic                   sram_we;
    logic [SADDR_WIDTH-1:0] sram_waddr;
    logic [DATA_WIDTH-1:0]  sram_wdata;
    logic                   sram_wrdy;
    logic                   done_vld;
    logic [3:0]             done_rid;
    logic                   done_err;
    logic                   idle;

    modport master (
        output cmd_vld, cmd_rid, cmd_sram_addr, cmd_beats,
        output axi_lsu_rvld, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast,
        output sram_wrdy,
        input  cmd_rdy, lsu_axi_rrdy, sram_we, sram_waddr, sram_wdata,
        input  done_vld, done_rid, done_err, idle
    );

    modport slave (
        input  cmd_vld, cmd_rid, cmd_sram_addr, cmd_beats,
        input  axi_lsu_rvld, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast,
        input  sram_wrdy,
        output cmd_rdy, lsu_axi_rrdy, sram_we, sram_waddr, sram_wdata,
        output done_vld, done_rid, done_err, idle
    );
endinterface

// File: rtl/lsu_rresp_sram_wr.sv
// lsu_rresp_sram_wr: writes AXI read-response beats into local SRAM via a 16-entry tag table.
// Define LSU_RRESP_BEAT_CHK_EN to flag beat-count mismatches against the commanded length.
module lsu_rresp_sram_wr #(
    parameter int ID_WIDTH    = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int SADDR_WIDTH = 12,
    parameter int NUM_TAG     = 16
) (
    input logic             clk,
    input logic             rst_n,
    lsu_rresp_sram_wr_if.slave bus
);
    typedef enum logic {FREE, ACTIVE} tag_st_e;

    tag_st_e                st_q   [NUM_TAG];
    tag_st_e                st_d   [NUM_TAG];
    logic [SADDR_WIDTH-1:0] addr_q [NUM_TAG];
    logic [SADDR_WIDTH-1:0] addr_d [NUM_TAG];
    logic                   err_q  [NUM_TAG];
    logic                   err_d  [NUM_TAG];
`ifdef LSU_RRESP_BEAT_CHK_EN
    logic [7:0]             rem_q  [NUM_TAG];
    logic [7:0]             rem_d  [NUM_TAG];
`endif

    logic                   pend_vld;
    logic [SADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0]  pend_data;
    logic                   done_vld_q;
    logic [3:0]             done_rid_q;
    logic                   done_err_q;

    logic [3:0] idx;
    logic       rrdy;
    logic       cmd_go;
    logic       acc;
    logic       hit;
    logic       beat_err;
    logic       beat_wr;
    logic       any_act;
    logic       unused_bits;

    assign idx    = bus.axi_lsu_rid[3:0];
    assign rrdy   = ~pend_vld | bus.sram_wrdy;
    assign acc    = bus.axi_lsu_rvld & rrdy;
    assign hit    = st_q[idx] == ACTIVE;
    assign cmd_go = bus.cmd_vld & (st_q[bus.cmd_rid] == FREE);

`ifdef LSU_RRESP_BEAT_CHK_EN
    // a non-last beat past the commanded length is flagged and dropped
    assign beat_err    = (bus.axi_lsu_rresp != 2'd0) |
                         (bus.axi_lsu_rlast ? rem_q[idx] != 8'd0 : rem_q[idx] == 8'd0);
    assign beat_wr     = acc & hit & (bus.axi_lsu_rlast | rem_q[idx] != 8'd0);
    assign unused_bits = ^bus.axi_lsu_rid[ID_WIDTH-1:4];
`else
    assign beat_err    = bus.axi_lsu_rresp != 2'd0;
    assign beat_wr     = acc & hit;
    assign unused_bits = ^{bus.axi_lsu_rid[ID_WIDTH-1:4], bus.cmd_beats};
`endif

    always_comb begin
        st_d    = st_q;
        addr_d  = addr_q;
        err_d   = err_q;
`ifdef LSU_RRESP_BEAT_CHK_EN
        rem_d   = rem_q;
`endif
        any_act = 1'b0;
        for (int i = 0; i < NUM_TAG; i++) any_act = any_act | (st_q[i] == ACTIVE);
        // cmd only allocates a FREE tag, and beats only update ACTIVE ones, so they never collide
        if (cmd_go) begin
            st_d[bus.cmd_rid]   = ACTIVE;
            addr_d[bus.cmd_rid] = bus.cmd_sram_addr;
            err_d[bus.cmd_rid]  = 1'b0;
`ifdef LSU_RRESP_BEAT_CHK_EN
            rem_d[bus.cmd_rid]  = bus.cmd_beats;
`endif
        end
        if (acc && hit) begin
            err_d[idx]  = err_q[idx] | beat_err;
            addr_d[idx] = beat_wr ? addr_q[idx] + SADDR_WIDTH'(1) : addr_q[idx];
`ifdef LSU_RRESP_BEAT_CHK_EN
            rem_d[idx]  = rem_q[idx] - 8'(rem_q[idx] != 8'd0);
`endif
            st_d[idx]   = bus.axi_lsu_rlast ? FREE : ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_TAG; i++) begin
                st_q[i]   <= FREE;
                addr_q[i] <= '0;
                err_q[i]  <= 1'b0;
`ifdef LSU_RRESP_BEAT_CHK_EN
                rem_q[i]  <= 8'd0;
`endif
            end
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            done_vld_q <= 1'b0;
            done_rid_q <= 4'd0;
            done_err_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            addr_q <= addr_d;
            err_q  <= err_d;
`ifdef LSU_RRESP_BEAT_CHK_EN
            rem_q  <= rem_d;
`endif
            if (beat_wr) begin
                pend_vld  <= 1'b1;
                pend_addr <= addr_q[idx];
                pend_data <= bus.axi_lsu_rdata;
            end else if (bus.sram_wrdy) begin
                pend_vld  <= 1'b0;
            end
            // unknown-tag beats complete immediately with an error
            done_vld_q <= acc & (~hit | bus.axi_lsu_rlast);
            if (acc) begin
                done_rid_q <= idx;
                done_err_q <= ~hit | err_q[idx] | beat_err;
            end
        end
    end

    assign bus.cmd_rdy      = st_q[bus.cmd_rid] == FREE;
    assign bus.lsu_axi_rrdy = rrdy;
    assign bus.sram_we      = pend_vld;
    assign bus.sram_waddr   = pend_addr;
    assign bus.sram_wdata   = pend_data;
    assign bus.done_vld     = done_vld_q;
    assign bus.done_rid     = done_rid_q;
    assign bus.done_err     = done_err_q;
    assign bus.idle         = ~any_act & ~pend_vld;
endmodule

// File: tb/tb_lsu_rresp_sram_wr.sv
// tb_lsu_rresp_sram_wr: directed stimulus with queued expectations checked by a separate output monitor.
module tb_lsu_rresp_sram_wr;
    localparam int IDW = 8;
    localparam int DW  = 64;
    localparam int AW  = 12;
`ifdef LSU_RRESP_BEAT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t        wq[$];
    logic [4:0] dq[$];
    wr_t        w;
    logic [4:0] e;

    always #5 clk = ~clk;

    lsu_rresp_sram_wr_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .SADDR_WIDTH(AW)) bus ();

    lsu_rresp_sram_wr #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .SADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            if (bus.sram_we && bus.sram_wrdy) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected write: addr %0h data %0h, none expected", bus.sram_waddr, bus.sram_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 64'(bus.sram_waddr), 64'(w.a));
                    chk("wr_data", bus.sram_wdata, w.d);
                end
            end
            if (bus.done_vld) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected done: rid %0d err %0b, none expected", bus.done_rid, bus.done_err);
                end else begin
                    e = dq.pop_front();
                    chk("done_rid", 64'(bus.done_rid), 64'(e[3:0]));
                    chk("done_err", 64'(bus.done_err), 64'(e[4]));
                end
            end
        end
    end

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wq.push_back('{a: a, d: d});
    endtask

    task automatic exp_done(input logic [3:0] rid, input logic err);
        dq.push_back({err, rid});
    endtask

    task automatic cmd(input logic [3:0] rid, input logic [AW-1:0] a, input logic [7:0] b);
        bus.cmd_rid = rid;
        bus.cmd_sram_addr = a;
        bus.cmd_beats = b;
        @(negedge clk);
        chk("cmd_rdy_free", 64'(bus.cmd_rdy), 64'd1);
        bus.cmd_vld = 1'b1;
        @(posedge clk);
        #1 bus.cmd_vld = 1'b0;
    endtask

    task automatic beat(input logic [IDW-1:0] rid, input logic [DW-1:0] d, input logic [1:0] r, input logic l);
        bit ok = 1'b0;
        bus.axi_lsu_rvld = 1'b1;
        bus.axi_lsu_rid = rid;
        bus.axi_lsu_rdata = d;
        bus.axi_lsu_rresp = r;
        bus.axi_lsu_rlast = l;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.lsu_axi_rrdy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: rid %0d never accepted within 50 cycles", rid);
        end
        @(posedge clk);
        #1 bus.axi_lsu_rvld = 1'b0;
    endtask

    initial begin
        bus.cmd_vld = 1'b0;
        bus.cmd_rid = 4'd0;
        bus.cmd_sram_addr = '0;
        bus.cmd_beats = 8'd0;
        bus.axi_lsu_rvld = 1'b0;
        bus.axi_lsu_rid = '0;
        bus.axi_lsu_rdata = '0;
        bus.axi_lsu_rresp = 2'd0;
        bus.axi_lsu_rlast = 1'b0;
        bus.sram_wrdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_we", 64'(bus.sram_we), 64'd0);
        chk("rst_waddr", 64'(bus.sram_waddr), 64'd0);
        chk("rst_wdata", bus.sram_wdata, 64'd0);
        chk("rst_done_vld", 64'(bus.done_vld), 64'd0);
        chk("rst_done_rid", 64'(bus.done_rid), 64'd0);
        chk("rst_done_err", 64'(bus.done_err), 64'd0);
        chk("rst_rrdy", 64'(bus.lsu_axi_rrdy), 64'd1);
        chk("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        chk("rst_idle", 64'(bus.idle), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;

        // single 4-beat burst
        for (int i = 0; i < 4; i++) exp_wr(AW'(12'h100 + i), 64'(8'hA0 + i));
        exp_done(4'd3, 1'b0);
        cmd(4'd3, 12'h100, 8'd3);
        chk("busy_idle", 64'(bus.idle), 64'd0);
        beat(8'd3, 64'hA0, 2'd0, 1'b0);
        chk("wr_latency_we", 64'(bus.sram_we), 64'd1);
        chk("wr_latency_addr", 64'(bus.sram_waddr), 64'h100);
        beat(8'd3, 64'hA1, 2'd0, 1'b0);
        beat(8'd3, 64'hA2, 2'd0, 1'b0);
        beat(8'd3, 64'hA3, 2'd0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after", 64'(bus.idle), 64'd1);

        // interleaved tags
        exp_wr(12'h010, 64'hB0);
        exp_wr(12'h020, 64'hC0);
        exp_wr(12'h011, 64'hB1);
        exp_wr(12'h021, 64'hC1);
        exp_done(4'd1, 1'b0);
        exp_done(4'd2, 1'b0);
        cmd(4'd1, 12'h010, 8'd1);
        cmd(4'd2, 12'h020, 8'd1);
        beat(8'd1, 64'hB0, 2'd0, 1'b0);
        beat(8'd2, 64'hC0, 2'd0, 1'b0);
        beat(8'd1, 64'hB1, 2'd0, 1'b1);
        beat(8'd2, 64'hC1, 2'd0, 1'b1);

        // SRAM backpressure holds the pending write and stalls beats
        exp_wr(12'h040, 64'hD0);
        exp_wr(12'h041, 64'hD1);
        exp_wr(12'h042, 64'hD2);
        exp_done(4'd4, 1'b0);
        cmd(4'd4, 12'h040, 8'd2);
        beat(8'd4, 64'hD0, 2'd0, 1'b0);
        bus.sram_wrdy = 1'b0;
        bus.axi_lsu_rvld = 1'b1;
        bus.axi_lsu_rdata = 64'hD1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rrdy", 64'(bus.lsu_axi_rrdy), 64'd0);
            chk("stall_we", 64'(bus.sram_we), 64'd1);
            chk("stall_addr", 64'(bus.sram_waddr), 64'h040);
            chk("stall_data", bus.sram_wdata, 64'hD0);
        end
        @(posedge clk);
        #1 bus.sram_wrdy = 1'b1;
        beat(8'd4, 64'hD1, 2'd0, 1'b0);
        beat(8'd4, 64'hD2, 2'd0, 1'b1);

        // error response mid-burst, then a beat for a free tag
        exp_wr(12'h050, 64'hE0);
        exp_wr(12'h051, 64'hE1);
        exp_wr(12'h052, 64'hE2);
        exp_done(4'd5, 1'b1);
        cmd(4'd5, 12'h050, 8'd2);
        beat(8'd5, 64'hE0, 2'd0, 1'b0);
        beat(8'd5, 64'hE1, 2'd2, 1'b0);
        beat(8'd5, 64'hE2, 2'd0, 1'b1);
        exp_done(4'd7, 1'b1);
        beat(8'd7, 64'hF0, 2'd0, 1'b1);

        // address wrap and cmd to an active tag
        exp_wr(12'hFFF, 64'h11);
        exp_wr(12'h000, 64'h12);
        exp_done(4'd6, 1'b0);
        cmd(4'd6, 12'hFFF, 8'd1);
        bus.cmd_rid = 4'd6;
        #1 chk("cmd_rdy_active", 64'(bus.cmd_rdy), 64'd0);
        beat(8'd6, 64'h11, 2'd0, 1'b0);
        beat(8'd6, 64'h12, 2'd0, 1'b1);
        @(negedge clk);
        chk("cmd_rdy_freed", 64'(bus.cmd_rdy), 64'd1);

        // early rlast: flagged only with beat-count checking
        exp_wr(12'h080, 64'h21);
        exp_wr(12'h081, 64'h22);
        exp_done(4'd8, CHK);
        cmd(4'd8, 12'h080, 8'd3);
        beat(8'd8, 64'h21, 2'd0, 1'b0);
        beat(8'd8, 64'h22, 2'd0, 1'b1);

        // reset mid-burst drops the tag
        exp_wr(12'h090, 64'h31);
        cmd(4'd9, 12'h090, 8'd3);
        beat(8'd9, 64'h31, 2'd0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", 64'(bus.sram_we), 64'd0);
        chk("mid_rst_done_vld", 64'(bus.done_vld), 64'd0);
        chk("mid_rst_rrdy", 64'(bus.lsu_axi_rrdy), 64'd1);
        chk("mid_rst_idle", 64'(bus.idle), 64'd1);
        for (int t = 0; t < 16; t++) begin
            bus.cmd_rid = 4'(t);
            #1 chk("mid_rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_done(4'd9, 1'b1);
        beat(8'd9, 64'h32, 2'd0, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("writes_left", 64'(wq.size()), 64'd0);
        chk("dones_left", 64'(dq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
